// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the push-button front end.
//   btn_state_t : press classifier state (IDLE, PRESSED, HELD)
//   speed_t     : speed index, 0 is slowest
//   BTN_MODE    : index of the MODE button in btn_i / short_o / long_o
//   BTN_SPEED   : index of the SPEED button
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  typedef logic [1:0] speed_t;

  localparam int BTN_MODE  = 0;
  localparam int BTN_SPEED = 1;

endpackage

// File: rtl/btn_mode_ctrl_if.sv
// btn_mode_ctrl_if: bundles the raw buttons and the decoded control outputs.
//   btn_i   : raw asynchronous buttons, bit 0 MODE, bit 1 SPEED
//   short_o : one-cycle pulse per button on release of a short press
//   long_o  : one-cycle pulse per button when the long threshold is reached
//   run_o   : 1 running, 0 paused
//   speed_o : speed index
//   step_o  : one-cycle single-step request (only while paused)
// Modports: slave is the controller side, master is the board/stimulus side.
interface btn_mode_ctrl_if;
  import btn_pkg::*;

  logic [1:0] btn_i;
  logic [1:0] short_o;
  logic [1:0] long_o;
  logic       run_o;
  speed_t     speed_o;
  logic       step_o;

  modport master (
    output btn_i,
    input  short_o, long_o, run_o, speed_o, step_o
  );

  modport slave (
    input  btn_i,
    output short_o, long_o, run_o, speed_o, step_o
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: single-button conditioning and press classification.
// Two-FF synchroniser, debounce counter producing a stable pressed level,
// then an IDLE/PRESSED/HELD classifier issuing short/long pulses.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   btn_i   : raw asynchronous button level
//   short_o : registered pulse, cycle after stable falls from PRESSED
//   long_o  : registered pulse, LONG_CYC edges after stable rose
module btn_debounce
  import btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 4,
  parameter int   LONG_CYC     = 20,
  parameter logic BTN_POLARITY = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic short_o,
  output logic long_o
);

  localparam int   CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int   HOLD_W   = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic RELEASED = ~BTN_POLARITY;

  logic              sync1_reg, sync2_reg;
  logic              level;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              stable_reg, stable_next;
  btn_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              short_reg, short_next;
  logic              long_reg, long_next;

  // 1 means pressed regardless of the board's button polarity.
  assign level = sync2_reg ^ ~BTN_POLARITY;

  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    if (level != stable_reg) begin
      if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_next = level;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // IDLE reacts to stable_next so PRESSED is entered on the same edge that
  // stable rises; the hold counter then counts edges since the rise.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stable_next && !stable_reg) begin
          state_next = PRESSED;
          hold_next  = '0;
        end
      end
      PRESSED: begin
        if (!stable_reg) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else if (hold_reg == HOLD_W'(LONG_CYC - 1)) begin
          long_next  = 1'b1;
          state_next = HELD;
        end else begin
          // Leaves PRESSED at LONG_CYC-1, so the count saturates there.
          hold_next = hold_reg + 1'b1;
        end
      end
      HELD: begin
        if (!stable_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_reg  <= RELEASED;
      sync2_reg  <= RELEASED;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      state_reg  <= IDLE;
      hold_reg   <= '0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
    end else begin
      sync1_reg  <= btn_i;
      sync2_reg  <= sync1_reg;
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      short_reg  <= short_next;
      long_reg   <= long_next;
    end
  end

  assign short_o = short_reg;
  assign long_o  = long_reg;

endmodule

// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: two-button front end producing run/pause, speed and
// single-step controls.
//   clk_i : system clock (only clock)
//   rst_i : synchronous active-high reset
//   bus   : btn_mode_ctrl_if.slave carrying btn_i and all control outputs
// MODE short toggles run; MODE long restores run=1/speed=0 and overrides
// everything else that cycle. SPEED short advances speed while running or
// requests a step while paused; SPEED long selects top speed while running.
module btn_mode_ctrl
  import btn_pkg::*;
#(
  parameter int   CLK_IN_MHZ   = 12,
  parameter int   DEBOUNCE_US  = 10000,
  parameter int   LONG_US      = 1000000,
  parameter logic BTN_POLARITY = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  btn_mode_ctrl_if.slave  bus
);

  localparam int DEBOUNCE_CYC = CLK_IN_MHZ * DEBOUNCE_US;
  localparam int LONG_CYC     = CLK_IN_MHZ * LONG_US;

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("btn_mode_ctrl: DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("btn_mode_ctrl: LONG_CYC must exceed DEBOUNCE_CYC");
  end

  logic [1:0] short_w;
  logic [1:0] long_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .BTN_POLARITY (BTN_POLARITY)
    ) u_btn (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (bus.btn_i[gi]),
      .short_o (short_w[gi]),
      .long_o  (long_w[gi])
    );
  end

  logic   run_reg, run_next;
  speed_t speed_reg, speed_next;
  logic   step_reg, step_next;

  always_comb begin
    run_next   = run_reg;
    speed_next = speed_reg;
    step_next  = 1'b0;
    if (long_w[BTN_MODE]) begin
      run_next   = 1'b1;
      speed_next = '0;
    end else begin
      if (short_w[BTN_MODE]) begin
        run_next = ~run_reg;
      end
      // Speed/step decisions look at run_reg, i.e. before any toggle above.
      if (short_w[BTN_SPEED]) begin
        if (run_reg) begin
          speed_next = speed_reg + 2'd1;
        end else begin
          step_next = 1'b1;
        end
      end else if (long_w[BTN_SPEED] && run_reg) begin
        speed_next = 2'd3;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_reg   <= 1'b1;
      speed_reg <= '0;
      step_reg  <= 1'b0;
    end else begin
      run_reg   <= run_next;
      speed_reg <= speed_next;
      step_reg  <= step_next;
    end
  end

  assign bus.short_o = short_w;
  assign bus.long_o  = long_w;
  assign bus.run_o   = run_reg;
  assign bus.speed_o = speed_reg;
  assign bus.step_o  = step_reg;

endmodule
